wr_line_packer: RTL and testbench

WR_LINE_PACKER -- requirements
Module: wr_line_packer

---
 rtl/wr_line_packer.sv | 165 ++++++++++++++++
 tb/tb_wr_line_packer.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wr_line_packer.sv
// Packs a stream of DATA_WIDTH scalars into cache lines and issues them as line writes.
// Completes a job once every issued write has been acknowledged on either response channel.
module wr_line_packer #(
   parameter int ADDR_LMT    = 20,
   parameter int MDATA       = 14,
   parameter int CACHE_WIDTH = 512,
   parameter int DATA_WIDTH  = 32
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   start,
   input  logic [ADDR_LMT-1:0]    base_line,
   input  logic                   in_valid,
   input  logic [DATA_WIDTH-1:0]  in_data,
   input  logic                   in_last,
   output logic                   in_ready,
   output logic [ADDR_LMT-1:0]    wr_req_addr,
   output logic [MDATA-1:0]       wr_req_mdata,
   output logic [CACHE_WIDTH-1:0] wr_req_data,
   output logic                   wr_req_en,
   input  logic                   wr_req_almostfull,
   input  logic                   wr_rsp_valid,
   input  logic                   wr_rsp_rvalid,
   output logic                   done
);

   localparam int LANES = CACHE_WIDTH / DATA_WIDTH;
   localparam int LW    = (LANES > 1) ? $clog2(LANES) : 1;
   localparam int CW    = 32;

   typedef enum logic [2:0] {
      S_IDLE,
      S_FILL,
      S_DRAIN,
      S_WAIT_RSP,
      S_DONE
   } state_t;

   state_t                 state_q;
   logic [ADDR_LMT-1:0]    base_q;
   logic [LW-1:0]          lane_q;
   logic [CACHE_WIDTH-1:0] fill_q;
   logic [CW-1:0]          issued_q;
   logic [CW-1:0]          rsp_q;
   logic [CACHE_WIDTH-1:0] fifo_q [2];
   logic                   wr_ptr_q;
   logic                   rd_ptr_q;
   logic [1:0]             cnt_q;
   logic                   wr_en_q;
   logic [ADDR_LMT-1:0]    wr_addr_q;
   logic [MDATA-1:0]       wr_mdata_q;
   logic [CACHE_WIDTH-1:0] wr_data_q;
   logic                   done_q;

   logic                   accept;
   logic                   push;
   logic                   pop;
   logic [CACHE_WIDTH-1:0] line_d;
   logic [CW-1:0]          rsp_inc;

   // Handshake: a scalar moves only on a rising edge where in_valid && in_ready.
   assign in_ready = (state_q == S_FILL) && (cnt_q != 2'd2);
   assign accept   = in_valid && in_ready;
   assign push     = accept && ((lane_q == LW'(LANES - 1)) || in_last);
   assign pop      = ((state_q == S_FILL) || (state_q == S_DRAIN)) &&
                     (cnt_q != 2'd0) && !wr_req_almostfull;
   assign rsp_inc  = CW'(wr_rsp_valid) + CW'(wr_rsp_rvalid);

   always_comb begin
      line_d = fill_q;
      line_d[int'(lane_q) * DATA_WIDTH +: DATA_WIDTH] = in_data;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_IDLE;
         base_q     <= '0;
         lane_q     <= '0;
         fill_q     <= '0;
         issued_q   <= '0;
         rsp_q      <= '0;
         fifo_q[0]  <= '0;
         fifo_q[1]  <= '0;
         wr_ptr_q   <= 1'b0;
         rd_ptr_q   <= 1'b0;
         cnt_q      <= 2'd0;
         wr_en_q    <= 1'b0;
         wr_addr_q  <= '0;
         wr_mdata_q <= '0;
         wr_data_q  <= '0;
         done_q     <= 1'b0;
      end else begin
         wr_en_q <= 1'b0;
         if (state_q != S_IDLE) begin
            rsp_q <= rsp_q + rsp_inc;
         end

         if (accept) begin
            if (push) begin
               fifo_q[wr_ptr_q] <= line_d;
               wr_ptr_q         <= ~wr_ptr_q;
               fill_q           <= '0;
               lane_q           <= '0;
            end else begin
               fill_q <= line_d;
               lane_q <= lane_q + LW'(1);
            end
         end

         if (pop) begin
            wr_en_q    <= 1'b1;
            wr_addr_q  <= base_q + ADDR_LMT'(issued_q);
            wr_mdata_q <= MDATA'(issued_q);
            wr_data_q  <= fifo_q[rd_ptr_q];
            rd_ptr_q   <= ~rd_ptr_q;
            issued_q   <= issued_q + CW'(1);
         end

         if (push && !pop) begin
            cnt_q <= cnt_q + 2'd1;
         end else if (!push && pop) begin
            cnt_q <= cnt_q - 2'd1;
         end

         case (state_q)
            S_IDLE, S_DONE: begin
               // A restart overrides the response accumulation made above.
               if (start) begin
                  base_q   <= base_line;
                  lane_q   <= '0;
                  fill_q   <= '0;
                  issued_q <= '0;
                  rsp_q    <= '0;
                  done_q   <= 1'b0;
                  state_q  <= S_FILL;
               end
            end
            S_FILL: begin
               if (accept && in_last) begin
                  state_q <= S_DRAIN;
               end
            end
            S_DRAIN: begin
               if ((cnt_q == 2'd0) && !wr_en_q) begin
                  state_q <= S_WAIT_RSP;
               end
            end
            S_WAIT_RSP: begin
               if (rsp_q == issued_q) begin
                  state_q <= S_DONE;
                  done_q  <= 1'b1;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign wr_req_en    = wr_en_q;
   assign wr_req_addr  = wr_addr_q;
   assign wr_req_mdata = wr_mdata_q;
   assign wr_req_data  = wr_data_q;
   assign done         = done_q;

endmodule

// File: tb/tb_wr_line_packer.sv
// Randomized scoreboard bench for wr_line_packer: each job's expected line writes are
// computed from its scalar list and compared by a monitor as writes appear.
module tb_wr_line_packer;

   localparam int AW   = 20;
   localparam int MW   = 14;
   localparam int CWID = 512;
   localparam int DW   = 32;
   localparam int L    = CWID / DW;
   localparam int EW   = AW + MW + CWID;

   logic            clk = 1'b0;
   logic            rst;
   logic            start;
   logic [AW-1:0]   base_line;
   logic            in_valid;
   logic [DW-1:0]   in_data;
   logic            in_last;
   logic            in_ready;
   logic [AW-1:0]   wr_req_addr;
   logic [MW-1:0]   wr_req_mdata;
   logic [CWID-1:0] wr_req_data;
   logic            wr_req_en;
   logic            wr_req_almostfull = 1'b0;
   logic            wr_rsp_valid;
   logic            wr_rsp_rvalid;
   logic            done;

   int n_checks    = 0;
   int n_errors    = 0;
   int writes_seen = 0;
   int accepted    = 0;
   int rsp_mode    = 0;   // 0: automatic responder, 1: main process drives responses
   int af_mode     = 0;   // 0: low, 1: high, 2: random
   int pending     = 0;

   logic [EW-1:0] exp_q[$];
   logic [DW-1:0] job_data[$];
   logic [EW-1:0] mon_exp;
   logic [EW-1:0] mon_act;

   wr_line_packer dut (
      .clk               (clk),
      .rst               (rst),
      .start             (start),
      .base_line         (base_line),
      .in_valid          (in_valid),
      .in_data           (in_data),
      .in_last           (in_last),
      .in_ready          (in_ready),
      .wr_req_addr       (wr_req_addr),
      .wr_req_mdata      (wr_req_mdata),
      .wr_req_data       (wr_req_data),
      .wr_req_en         (wr_req_en),
      .wr_req_almostfull (wr_req_almostfull),
      .wr_rsp_valid      (wr_rsp_valid),
      .wr_rsp_rvalid     (wr_rsp_rvalid),
      .done              (done)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      case (af_mode)
         0:       wr_req_almostfull = 1'b0;
         1:       wr_req_almostfull = 1'b1;
         default: wr_req_almostfull = ($urandom_range(0, 3) == 0);
      endcase
   end

   // Acknowledges each observed write once, with random delay and channel choice.
   always @(negedge clk) begin
      if (rsp_mode == 0) begin
         wr_rsp_valid  = 1'b0;
         wr_rsp_rvalid = 1'b0;
         if (rst) begin
            pending = 0;
         end else begin
            if (wr_req_en) pending++;
            if (pending > 0 && $urandom_range(0, 2) != 0) begin
               wr_rsp_valid = 1'b1;
               pending--;
            end
            if (pending > 0 && $urandom_range(0, 2) == 0) begin
               wr_rsp_rvalid = 1'b1;
               pending--;
            end
         end
      end else begin
         pending = 0;
      end
   end

   always @(negedge clk) begin
      if (!rst && wr_req_en) begin
         writes_seen++;
         n_checks++;
         mon_act = {wr_req_addr, wr_req_mdata, wr_req_data};
         if (exp_q.size() == 0) begin
            n_errors++;
            $display("FAIL unexpected_write: addr=%h mdata=%h with nothing expected",
                     wr_req_addr, wr_req_mdata);
         end else begin
            mon_exp = exp_q.pop_front();
            if (mon_act !== mon_exp) begin
               n_errors++;
               $display("FAIL write: got addr=%h mdata=%h data=%h expected addr=%h mdata=%h data=%h",
                        mon_act[EW-1 -: AW], mon_act[CWID +: MW], mon_act[CWID-1:0],
                        mon_exp[EW-1 -: AW], mon_exp[CWID +: MW], mon_exp[CWID-1:0]);
            end
         end
      end
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Line i holds scalars i*L .. i*L+L-1 (missing ones zero), goes to base+i with tag i.
   task automatic expect_job(input logic [AW-1:0] base);
      int nlines = (job_data.size() + L - 1) / L;
      for (int i = 0; i < nlines; i++) begin
         logic [CWID-1:0] line;
         line = '0;
         for (int k = 0; k < L; k++) begin
            if (i * L + k < job_data.size()) line[k*DW +: DW] = job_data[i*L + k];
         end
         exp_q.push_back({base + AW'(i), MW'(i), line});
      end
   endtask

   task automatic start_job(input logic [AW-1:0] base);
      @(negedge clk);
      start     = 1'b1;
      base_line = base;
      @(negedge clk);
      start     = 1'b0;
   endtask

   task automatic send_scalars(input int n, input bit do_last, input int gap_max);
      int i = 0;
      int c = 0;
      while (i < n && c < 3000) begin
         @(negedge clk);
         c++;
         if (gap_max > 0 && $urandom_range(0, gap_max) == 0) begin
            in_valid = 1'b0;
            in_last  = 1'b0;
         end else begin
            in_valid = 1'b1;
            in_data  = job_data[i];
            in_last  = do_last && (i == n - 1);
            if (in_ready) begin
               i++;
               accepted++;
            end
         end
      end
      @(negedge clk);
      in_valid = 1'b0;
      in_last  = 1'b0;
      if (i < n) begin
         n_checks++;
         n_errors++;
         $display("FAIL send_timeout: accepted %0d of %0d scalars", i, n);
      end
   endtask

   task automatic wait_done(input string name, input int bound);
      int c = 0;
      while (!done && c < bound) begin
         @(negedge clk);
         c++;
      end
      check({name, "_done"}, 64'(done), 64'd1);
      check({name, "_ready_in_done"}, 64'(in_ready), 64'd0);
      check({name, "_sb_empty"}, 64'(exp_q.size()), 64'd0);
   endtask

   task automatic run_job(input string name, input logic [AW-1:0] base, input int gap_max);
      expect_job(base);
      start_job(base);
      check({name, "_done_cleared"}, 64'(done), 64'd0);
      send_scalars(job_data.size(), 1'b1, gap_max);
      wait_done(name, 2000);
   endtask

   task automatic check_reset_outputs(input string name);
      check({name, "_in_ready"}, 64'(in_ready), 64'd0);
      check({name, "_wr_en"}, 64'(wr_req_en), 64'd0);
      check({name, "_done"}, 64'(done), 64'd0);
      check({name, "_addr"}, 64'(wr_req_addr), 64'd0);
      check({name, "_mdata"}, 64'(wr_req_mdata), 64'd0);
      check({name, "_data_zero"}, 64'(wr_req_data != '0), 64'd0);
   endtask

   initial begin
      int w0;
      int c;
      rst           = 1'b1;
      start         = 1'b0;
      base_line     = '0;
      in_valid      = 1'b0;
      in_data       = '0;
      in_last       = 1'b0;
      wr_rsp_valid  = 1'b0;
      wr_rsp_rvalid = 1'b0;
      repeat (3) @(negedge clk);
      check_reset_outputs("reset");
      rst = 1'b0;
      @(negedge clk);

      // One full line, no backpressure.
      job_data.delete();
      for (int k = 0; k < 16; k++) job_data.push_back(DW'(k + 1));
      run_job("one_line", 20'h00100, 0);

      // Partial second line; a start pulse mid-job must be ignored.
      job_data.delete();
      for (int k = 0; k < 20; k++) job_data.push_back(DW'(k + 1));
      expect_job(20'h00100);
      start_job(20'h00100);
      fork
         send_scalars(20, 1'b1, 2);
         begin
            repeat (6) @(negedge clk);
            start     = 1'b1;
            base_line = 20'h00555;
            @(negedge clk);
            start     = 1'b0;
         end
      join
      wait_done("partial_line", 2000);

      // Backpressure fills the two-line FIFO, then drains in order.
      job_data.delete();
      for (int k = 0; k < 48; k++) job_data.push_back(DW'(k + 1));
      af_mode = 1;
      expect_job(20'h00040);
      start_job(20'h00040);
      accepted = 0;
      w0 = writes_seen;
      fork
         send_scalars(48, 1'b1, 0);
         begin
            repeat (60) @(negedge clk);
            check("af_accepted", 64'(accepted), 64'd32);
            check("af_in_ready", 64'(in_ready), 64'd0);
            check("af_wr_en", 64'(wr_req_en), 64'd0);
            check("af_no_writes", 64'(writes_seen - w0), 64'd0);
            af_mode = 0;
         end
      join
      wait_done("backpressure", 2000);

      // Both response channels in one cycle count twice.
      rsp_mode      = 1;
      wr_rsp_valid  = 1'b0;
      wr_rsp_rvalid = 1'b0;
      job_data.delete();
      for (int k = 0; k < 32; k++) job_data.push_back($urandom);
      w0 = writes_seen;
      expect_job(20'h00300);
      start_job(20'h00300);
      send_scalars(32, 1'b1, 1);
      c = 0;
      while (writes_seen < w0 + 2 && c < 500) begin
         @(negedge clk);
         c++;
      end
      check("dual_writes", 64'(writes_seen - w0), 64'd2);
      repeat (4) @(negedge clk);
      check("dual_not_done_yet", 64'(done), 64'd0);
      wr_rsp_valid  = 1'b1;
      wr_rsp_rvalid = 1'b1;
      @(negedge clk);
      wr_rsp_valid  = 1'b0;
      wr_rsp_rvalid = 1'b0;
      check("dual_done_after_1", 64'(done), 64'd0);
      @(negedge clk);
      check("dual_done_after_2", 64'(done), 64'd1);
      check("dual_sb_empty", 64'(exp_q.size()), 64'd0);
      rsp_mode = 0;

      // Reset mid-job aborts; next job contains only its own scalars.
      job_data.delete();
      for (int k = 0; k < 5; k++) job_data.push_back($urandom);
      start_job(20'h00180);
      send_scalars(5, 1'b0, 0);
      rst = 1'b1;
      repeat (2) @(negedge clk);
      check_reset_outputs("midjob_reset");
      rst = 1'b0;
      repeat (3) @(negedge clk);
      check("post_reset_no_write", 64'(wr_req_en), 64'd0);
      job_data.delete();
      for (int k = 0; k < 16; k++) job_data.push_back(DW'(100 + k));
      run_job("after_abort", 20'h00200, 1);

      // Address wraps past the top of the line space.
      job_data.delete();
      for (int k = 0; k < 32; k++) job_data.push_back($urandom);
      run_job("wrap", 20'hFFFFF, 1);

      // Random jobs with random backpressure and response timing.
      af_mode = 2;
      for (int r = 0; r < 4; r++) begin
         int n;
         n = $urandom_range(1, 40);
         job_data.delete();
         for (int k = 0; k < n; k++) job_data.push_back($urandom);
         run_job($sformatf("rand%0d", r), AW'($urandom_range(0, 20'hFFFFF)), 3);
      end
      af_mode = 0;

      repeat (5) @(negedge clk);
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
